// File: rtl/alu_share_arb_if.sv
// ---------------------------------------------------------------------------
// alu_share_arb_if : request/response bundle between two issuers and the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_share_arb_if #(
  parameter int W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][W-1:0] req_a;
  logic [1:0][W-1:0] req_b;
  logic [1:0][2:0]   req_f;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [W-1:0]      resp_y;
  logic              resp_cout;
  logic              resp_ovf;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, req_f, resp_ready,
    output req_ready, resp_valid, resp_y, resp_cout, resp_ovf, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_f, resp_ready,
    input  req_ready, resp_valid, resp_y, resp_cout, resp_ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb : two-requester round-robin sequencer time-sharing one alu32.
// Optional macro ALU_SHARE_ARB_FLAGS_EN registers Cout/Overflow onto the response.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu32 (
  input  wire logic [31:0] i_a,
  input  wire logic [31:0] i_b,
  input  wire logic [2:0]  i_f,
  output logic      [31:0] o_y,
  output logic             o_cout,
  output logic             o_ovf
);
  logic [31:0] w_bb;
  logic [32:0] w_sum;

  assign w_bb  = i_f[2] ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_bb} + {32'b0, i_f[2]};

  always_comb begin
    o_y = '0;
    case (i_f[1:0])
      2'b00:   o_y = i_a & w_bb;
      2'b01:   o_y = i_a | w_bb;
      2'b10:   o_y = w_sum[31:0];
      default: o_y = {31'b0, w_sum[31]};
    endcase
  end

  assign o_cout = w_sum[32];
  // Comparing A against the possibly-inverted B gives the ADD or SUB overflow rule.
  assign o_ovf  = (i_a[31] == w_bb[31]) && (w_sum[31] != i_a[31]);
endmodule

module alu_share_arb #(
  parameter int W = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  alu_share_arb_if.slave  bus
);
  if (W != 32) begin : g_width_check
    $error("alu_share_arb: W must be 32 to match alu32");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_last_grant;
  logic         r_owner;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [2:0]   r_f;
  logic [W-1:0] r_y;

  logic         w_winner;
  logic         w_accept;
  logic [1:0]   w_req_ready;
  logic [1:0]   w_resp_valid;
  logic [W-1:0] w_alu_y;
  logic         w_alu_cout;
  logic         w_alu_ovf;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_winner = 1'b0;
    case (bus.req_valid)
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last_grant;
      default: w_winner = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_req_ready  = 2'b00;
    w_resp_valid = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (!reset && (bus.req_valid != 2'b00)) begin
          w_req_ready[w_winner] = 1'b1;
          w_accept              = 1'b1;
          w_next                = S_EXEC;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        w_resp_valid[r_owner] = 1'b1;
        if (bus.resp_ready[r_owner]) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_f          <= '0;
      r_y          <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a          <= bus.req_a[w_winner];
        r_b          <= bus.req_b[w_winner];
        r_f          <= bus.req_f[w_winner];
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
      end
      if (r_state == S_EXEC) begin
        r_y <= w_alu_y;
      end
    end
  end

  // The ALU only ever sees the captured operands, so the request payload may move freely.
  alu32 u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_f    (r_f),
    .o_y    (w_alu_y),
    .o_cout (w_alu_cout),
    .o_ovf  (w_alu_ovf)
  );

`ifdef ALU_SHARE_ARB_FLAGS_EN
  logic r_cout;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_cout <= w_alu_cout;
      r_ovf  <= w_alu_ovf;
    end
  end

  assign bus.resp_cout = r_cout;
  assign bus.resp_ovf  = r_ovf;
`else
  logic w_unused_flags;
  assign w_unused_flags = w_alu_cout ^ w_alu_ovf;
  assign bus.resp_cout  = 1'b0;
  assign bus.resp_ovf   = 1'b0;
`endif

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_y     = r_y;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb : scoreboard bench for the shared-ALU round-robin sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_share_arb;
`ifdef ALU_SHARE_ARB_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_arb_if #(.W(32)) bus ();

  alu_share_arb #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] y;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference: {cout, ovf, y}; overflow judged from a wide signed result.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f);
    logic [32:0] wide;
    longint      sa, sbv, sr;
    logic [31:0] y;
    logic        ov;
    wide = f[2] ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    sr   = f[2] ? (sa - sbv) : (sa + sbv);
    ov   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    case (f)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b111:  y = {31'b0, wide[31]};
      default: y = wide[31:0];
    endcase
    return {wide[32], ov, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // Raise valid for requester r, wait for its grant, record expectation, let the edge accept.
  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, output bit tmo);
    exp_t        e;
    logic [33:0] m;
    bus.req_a[r] = a;
    bus.req_b[r] = b;
    bus.req_f[r] = f;
    bus.req_valid[r] = 1'b1;
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready[r]) begin
        tmo = 1'b0;
        break;
      end
      tick();
    end
    if (!tmo) begin
      m     = model(a, b, f);
      e.vld = 2'b01 << r;
      e.y   = m[31:0];
      e.c   = m[33] & FLAGS_EN;
      e.o   = m[32] & FLAGS_EN;
      sb.push_back(e);
      tick();
    end
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_resp(output logic [1:0] v, output logic [31:0] y, output logic c,
                           output logic o, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.resp_valid != 2'b00) begin
        tmo = 1'b0;
        break;
      end
      tick();
    end
    v = bus.resp_valid;
    y = bus.resp_y;
    c = bus.resp_cout;
    o = bus.resp_ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 2'b11;
    tick();
    #1;
    n_total++; if (bus.req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); else n_pass++;
    n_total++; if (bus.resp_valid !== 2'b00) $display("FAIL rst_resp_valid: got %b want 00", bus.resp_valid); else n_pass++;
    n_total++; if (bus.resp_y !== 32'h0) $display("FAIL rst_resp_y: got %h want 0", bus.resp_y); else n_pass++;
    n_total++; if (bus.resp_cout !== 1'b0) $display("FAIL rst_cout: got %b want 0", bus.resp_cout); else n_pass++;
    n_total++; if (bus.resp_ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", bus.resp_ovf); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (bus.req_ready !== 2'b01) $display("FAIL first_tie_grant: got %b want 01", bus.req_ready); else n_pass++;
    bus.req_valid = 2'b10;
    #1;
    n_total++; if (bus.req_ready !== 2'b10) $display("FAIL single_grant_r1: got %b want 10", bus.req_ready); else n_pass++;
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_add();
    bit   tmo;
    exp_t e;
    bus.resp_ready = 2'b00;
    issue(0, 32'd5, 32'd7, 3'b010, tmo);
    n_total++; if (tmo || sb.size() == 0) $display("FAIL add_accept: timed out"); else n_pass++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      #1;
      n_total++; if (bus.resp_valid !== 2'b00) $display("FAIL add_exec_valid: got %b want 00", bus.resp_valid); else n_pass++;
      n_total++; if (bus.busy !== 1'b1) $display("FAIL add_exec_busy: got %b want 1", bus.busy); else n_pass++;
      tick();
      #1;
      n_total++; if (bus.resp_valid !== e.vld) $display("FAIL add_resp_valid: got %b want %b", bus.resp_valid, e.vld); else n_pass++;
      n_total++; if (bus.resp_y !== e.y) $display("FAIL add_resp_y: got %h want %h", bus.resp_y, e.y); else n_pass++;
      n_total++; if (bus.resp_cout !== e.c) $display("FAIL add_cout: got %b want %b", bus.resp_cout, e.c); else n_pass++;
      n_total++; if (bus.resp_ovf !== e.o) $display("FAIL add_ovf: got %b want %b", bus.resp_ovf, e.o); else n_pass++;
      bus.resp_ready = 2'b01;
      tick();
      #1;
      n_total++; if (bus.resp_valid !== 2'b00) $display("FAIL add_done_valid: got %b want 00", bus.resp_valid); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL add_done_busy: got %b want 0", bus.busy); else n_pass++;
    end
    bus.resp_ready = 2'b00;
  endtask

  task automatic test_sub_flags();
    bit          tmo;
    exp_t        e;
    logic [1:0]  v;
    logic [31:0] y;
    logic        c, o;
    bus.resp_ready = 2'b10;
    issue(1, 32'h8000_0000, 32'h0000_0001, 3'b110, tmo);
    wait_resp(v, y, c, o, tmo);
    if (tmo || sb.size() == 0) begin
      n_total++; $display("FAIL sub_resp_timeout: got %b want response", v);
    end else begin
      e = sb.pop_front();
      n_total++; if (v !== e.vld) $display("FAIL sub_resp_valid: got %b want %b", v, e.vld); else n_pass++;
      n_total++; if (y !== e.y) $display("FAIL sub_resp_y: got %h want %h", y, e.y); else n_pass++;
      n_total++; if (c !== e.c) $display("FAIL sub_cout: got %b want %b", c, e.c); else n_pass++;
      n_total++; if (o !== e.o) $display("FAIL sub_ovf: got %b want %b", o, e.o); else n_pass++;
    end
    tick();
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL sub_done_busy: got %b want 0", bus.busy); else n_pass++;
    bus.resp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [33:0] m;
    logic [1:0]  want;
    int          grants = 0;
    int          resps  = 0;
    int          last_cyc = 0;
    do_reset();
    bus.resp_ready = 2'b11;
    for (int r = 0; r < 2; r++) begin
      bus.req_a[r] = 32'd3;
      bus.req_b[r] = 32'd9;
      bus.req_f[r] = 3'b111;
    end
    bus.req_valid = 2'b11;
    m = model(32'd3, 32'd9, 3'b111);
    for (int cyc = 0; cyc < 60 && resps < 4; cyc++) begin
      #1;
      if (bus.resp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          n_total++; $display("FAIL b2b_extra_resp: got %b want none", bus.resp_valid);
        end else begin
          e = sb.pop_front();
          n_total++; if (bus.resp_valid !== e.vld) $display("FAIL b2b_resp_owner: got %b want %b", bus.resp_valid, e.vld); else n_pass++;
          n_total++; if (bus.resp_y !== e.y) $display("FAIL b2b_resp_y: got %h want %h", bus.resp_y, e.y); else n_pass++;
        end
        resps++;
      end
      if (bus.req_ready != 2'b00 && grants < 4) begin
        want = (grants % 2 == 0) ? 2'b01 : 2'b10;
        n_total++; if (bus.req_ready !== want) $display("FAIL b2b_grant%0d: got %b want %b", grants, bus.req_ready, want); else n_pass++;
        if (grants > 0) begin
          n_total++; if (cyc - last_cyc != 3) $display("FAIL b2b_interval: got %0d want 3", cyc - last_cyc); else n_pass++;
        end
        last_cyc = cyc;
        e.vld = want;
        e.y   = m[31:0];
        e.c   = m[33] & FLAGS_EN;
        e.o   = m[32] & FLAGS_EN;
        sb.push_back(e);
        grants++;
      end
      tick();
      if (grants == 4) bus.req_valid = 2'b00;
    end
    n_total++; if (resps < 4) $display("FAIL b2b_timeout: got %0d want 4 responses", resps); else n_pass++;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    bit          tmo;
    exp_t        e;
    logic [1:0]  v;
    logic [31:0] y;
    logic        c, o;
    bus.resp_ready = 2'b00;
    issue(0, 32'h1234_5678, 32'h1111_1111, 3'b010, tmo);
    wait_resp(v, y, c, o, tmo);
    if (tmo || sb.size() == 0) begin
      n_total++; $display("FAIL bp_resp_timeout: got %b want response", v);
    end else begin
      e = sb.pop_front();
      n_total++; if (y !== e.y) $display("FAIL bp_resp_y: got %h want %h", y, e.y); else n_pass++;
      bus.req_a[1] = 32'd40;
      bus.req_b[1] = 32'd2;
      bus.req_f[1] = 3'b010;
      bus.req_valid = 2'b10;
      bus.resp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
        tick();
        #1;
        n_total++; if (bus.resp_valid !== 2'b01) $display("FAIL bp_hold_valid: got %b want 01", bus.resp_valid); else n_pass++;
        n_total++; if (bus.resp_y !== e.y) $display("FAIL bp_hold_y: got %h want %h", bus.resp_y, e.y); else n_pass++;
        n_total++; if (bus.req_ready !== 2'b00) $display("FAIL bp_req_ready: got %b want 00", bus.req_ready); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", bus.busy); else n_pass++;
      end
      bus.resp_ready = 2'b01;
      tick();
      #1;
      n_total++; if (bus.resp_valid !== 2'b00) $display("FAIL bp_release_valid: got %b want 00", bus.resp_valid); else n_pass++;
      n_total++; if (bus.req_ready !== 2'b10) $display("FAIL bp_waiting_grant: got %b want 10", bus.req_ready); else n_pass++;
      bus.resp_ready = 2'b10;
      issue(1, 32'd40, 32'd2, 3'b010, tmo);
      wait_resp(v, y, c, o, tmo);
      if (tmo || sb.size() == 0) begin
        n_total++; $display("FAIL bp_next_timeout: got %b want response", v);
      end else begin
        e = sb.pop_front();
        n_total++; if (v !== e.vld) $display("FAIL bp_next_owner: got %b want %b", v, e.vld); else n_pass++;
        n_total++; if (y !== e.y) $display("FAIL bp_next_y: got %h want %h", y, e.y); else n_pass++;
      end
      tick();
    end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
  endtask

  task automatic test_reset_exec();
    bit          tmo;
    exp_t        e;
    logic [1:0]  v;
    logic [31:0] y;
    logic        c, o;
    bus.resp_ready = 2'b11;
    issue(1, 32'd1, 32'd2, 3'b010, tmo);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rx_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.resp_y !== 32'h0) $display("FAIL rx_resp_y: got %h want 0", bus.resp_y); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (bus.resp_valid !== 2'b00) $display("FAIL rx_no_resp: got %b want 00", bus.resp_valid); else n_pass++;
      tick();
    end
    for (int r = 0; r < 2; r++) begin
      bus.req_a[r] = 32'd10;
      bus.req_b[r] = 32'd20;
      bus.req_f[r] = 3'b010;
    end
    bus.req_valid = 2'b11;
    #1;
    n_total++; if (bus.req_ready !== 2'b01) $display("FAIL rx_tie_grant: got %b want 01", bus.req_ready); else n_pass++;
    issue(0, 32'd10, 32'd20, 3'b010, tmo);
    bus.req_valid = 2'b00;
    wait_resp(v, y, c, o, tmo);
    if (tmo || sb.size() == 0) begin
      n_total++; $display("FAIL rx_next_timeout: got %b want response", v);
    end else begin
      e = sb.pop_front();
      n_total++; if (v !== e.vld) $display("FAIL rx_next_owner: got %b want %b", v, e.vld); else n_pass++;
      n_total++; if (y !== e.y) $display("FAIL rx_next_y: got %h want %h", y, e.y); else n_pass++;
    end
    tick();
    bus.resp_ready = 2'b00;
  endtask

  task automatic test_or_and();
    bit          tmo;
    exp_t        e;
    logic [1:0]  v;
    logic [31:0] y;
    logic        c, o;
    logic [2:0]  fs [2];
    fs[0] = 3'b001;
    fs[1] = 3'b000;
    bus.resp_ready = 2'b01;
    for (int k = 0; k < 2; k++) begin
      issue(0, 32'hF0F0_0000, 32'h0000_F0F0, fs[k], tmo);
      wait_resp(v, y, c, o, tmo);
      if (tmo || sb.size() == 0) begin
        n_total++; $display("FAIL logic%0d_timeout: got %b want response", k, v);
      end else begin
        e = sb.pop_front();
        n_total++; if (v !== e.vld) $display("FAIL logic%0d_owner: got %b want %b", k, v, e.vld); else n_pass++;
        n_total++; if (y !== e.y) $display("FAIL logic%0d_y: got %h want %h", k, y, e.y); else n_pass++;
      end
      tick();
    end
    bus.resp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_f      = '0;
    tick();
    tick();
    test_reset();
    test_add();
    test_sub_flags();
    test_back_to_back();
    test_backpressure();
    test_reset_exec();
    test_or_and();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
